// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the WISC-SP13 fetch stage.
package fetch_stage_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = 16'h0800;
    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    typedef enum logic {
        RUN       = 1'b0,
        HALT_SEEN = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_stage_reg16_en.sv
// 16-bit register with load enable and a parameterised synchronous reset value.
module reg16_en
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [INSTR_W-1:0] d,
    output logic [INSTR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID latch: PC, stall/redirect handling, HALT stop.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_pc,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_pc_plus2,
    output logic               if_id_valid,
    output logic               halted,
    output logic               err,
    output fetch_state_e       fsm_state
);

    fetch_state_e       state, state_next;
    logic [INSTR_W-1:0] pc, pc_d, pc_plus2, instr_d;
    logic               pc_en, instr_en, pp2_en;
    logic               valid_d, halted_d, err_d;

    assign imem_addr = pc;
    assign fsm_state = state;
    assign pc_plus2  = pc + 16'd2;

    reg16_en #(.RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc)
    );

    reg16_en #(.RESET_VAL(NOP)) u_if_id_instr (
        .clk(clk), .rst(rst), .en(instr_en), .d(instr_d), .q(if_id_instr)
    );

    reg16_en #(.RESET_VAL(16'h0000)) u_if_id_pc_plus2 (
        .clk(clk), .rst(rst), .en(pp2_en), .d(pc_plus2), .q(if_id_pc_plus2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            if_id_valid <= valid_d;
            halted      <= halted_d;
            err         <= err_d;
        end
    end

    // Priority below reset: redirect, then stall, then normal fetch.
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        pc_d       = pc;
        instr_en   = 1'b0;
        instr_d    = NOP;
        pp2_en     = 1'b0;
        valid_d    = if_id_valid;
        halted_d   = halted;
        err_d      = err;

        if (redirect) begin
            pc_en      = 1'b1;
            pc_d       = redirect_pc;
            instr_en   = 1'b1;
            valid_d    = 1'b0;
            state_next = RUN;
            halted_d   = 1'b0;
            err_d      = err | redirect_pc[0];
        end else if (!stall) begin
            unique case (state)
                RUN: begin
                    instr_en = 1'b1;
                    instr_d  = imem_data;
                    pp2_en   = 1'b1;
                    valid_d  = 1'b1;
                    if (is_halt(imem_data)) begin
                        state_next = HALT_SEEN;
                        halted_d   = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        pc_d  = pc_plus2;
                    end
                end
                HALT_SEEN: begin
                    // PC and pc_plus2 hold; only bubbles enter IF/ID.
                    instr_en = 1'b1;
                    valid_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus randomized run against a model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic        err;
    logic        fsm_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:32767];

    assign imem_data = mem[imem_addr[15:1]];

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid(if_id_valid), .halted(halted), .err(err),
        .fsm_state(fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
        logic        halted;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    // behavioural model state
    logic [15:0] m_pc, m_instr, m_pp2;
    logic        m_valid, m_halted, m_err;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic add(input logic r, s, rd, input logic [15:0] rpc,
                       input logic [15:0] pc, instr, pp2, input logic v, h, e);
        vec_t x;
        x.rst = r; x.stall = s; x.redirect = rd; x.rpc = rpc;
        x.pc = pc; x.instr = instr; x.pp2 = pp2; x.valid = v; x.halted = h; x.err = e;
        vecs.push_back(x);
    endtask

    // Model of one clock edge, straight from the stage's update rules.
    task automatic model_step(input logic r, s, rd, input logic [15:0] rpc, input logic [15:0] word);
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0800; m_pp2 = 16'h0000;
            m_valid = 0; m_halted = 0; m_err = 0;
        end else if (rd) begin
            m_pc = rpc; m_instr = 16'h0800; m_valid = 0; m_halted = 0;
            if (rpc[0]) m_err = 1;
        end else if (s) begin
            // hold everything
        end else if (m_halted) begin
            m_instr = 16'h0800; m_valid = 0;
        end else begin
            m_instr = word; m_pp2 = m_pc + 16'd2; m_valid = 1;
            if (word[15:11] == 5'b00000) m_halted = 1;
            else m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic check_model();
        check("rnd_imem_addr", imem_addr, m_pc);
        check("rnd_instr", if_id_instr, m_instr);
        check("rnd_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
        check("rnd_halted", {15'd0, halted}, {15'd0, m_halted});
        check("rnd_err", {15'd0, err}, {15'd0, m_err});
        if (m_valid) check("rnd_pc_plus2", if_id_pc_plus2, m_pp2);
    endtask

    initial begin
        drive(1, 0, 0, 16'h0000);
        for (int i = 0; i < 32768; i++) mem[i] = 16'h4000 | 16'(i[10:0]);
        mem[0] = 16'hC001;
        mem[1] = 16'hC102;
        mem[4] = 16'h0000;  // HALT at address 8

        //  rst st rd rpc        pc        instr     pp2      v h e
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0002, 16'hC001, 16'h0002, 1, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0004, 16'hC102, 16'h0004, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0004, 16'hC102, 16'h0004, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0004, 16'hC102, 16'h0004, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 16'h0004, 16'hC102, 16'h0004, 1, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0006, 16'h4002, 16'h0006, 1, 0, 0);
        add(0, 1, 1, 16'h0040, 16'h0040, 16'h0800, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0042, 16'h4020, 16'h0042, 1, 0, 0);
        add(0, 0, 1, 16'h0008, 16'h0008, 16'h0800, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0008, 16'h0000, 16'h000A, 1, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0008, 16'h0800, 16'h0000, 0, 1, 0);
        add(0, 1, 0, 16'h0000, 16'h0008, 16'h0800, 16'h0000, 0, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0008, 16'h0800, 16'h0000, 0, 1, 0);
        add(0, 0, 1, 16'h0010, 16'h0010, 16'h0800, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0012, 16'h4008, 16'h0012, 1, 0, 0);
        add(0, 0, 1, 16'h0013, 16'h0013, 16'h0800, 16'h0000, 0, 0, 1);
        add(0, 0, 0, 16'h0000, 16'h0015, 16'h4009, 16'h0015, 1, 0, 1);
        add(0, 0, 1, 16'hFFFE, 16'hFFFE, 16'h0800, 16'h0000, 0, 0, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h47FF, 16'h0000, 1, 0, 1);
        add(0, 1, 0, 16'h0000, 16'h0000, 16'h47FF, 16'h0000, 1, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0);
        add(0, 0, 1, 16'h0008, 16'h0008, 16'h0800, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 16'h0008, 16'h0000, 16'h000A, 1, 1, 0);
        add(1, 0, 1, 16'h0021, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].pc);
            check($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].instr);
            check($sformatf("vec%0d_valid", i), {15'd0, if_id_valid}, {15'd0, vecs[i].valid});
            check($sformatf("vec%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].halted});
            check($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, vecs[i].err});
            if (vecs[i].valid || vecs[i].rst)
                check($sformatf("vec%0d_pc_plus2", i), if_id_pc_plus2, vecs[i].pp2);
        end

        // randomized phase: fresh memory with roughly 1 in 12 words a HALT
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 11) == 0) mem[i][15:11] = 5'b00000;
        end
        mem[32767] = 16'h5555;
        drive(1, 0, 0, 16'h0000);
        model_step(1, 0, 0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        check_model();
        for (int n = 0; n < 3000; n++) begin
            logic r, s, rd;
            logic [15:0] rpc;
            logic [15:0] word;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 19) == 0) rpc[0] = 1'b1;
            if ($urandom_range(0, 9) == 0) rpc = 16'hFFFC;
            drive(r, s, rd, rpc);
            word = mem[m_pc[15:1]];
            model_step(r, s, rd, rpc, word);
            @(posedge clk);
            #1;
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
